thrfsm_hang_det: RTL and testbench
==================================

# thrfsm_hang_det

Per-core thread hang detector that consumes the IFU thread-FSM state and wait masks and flags any thread held in the wait state for too long. It sits beside the per-core thread-FSM checker in the manycore verification environment. It is driven from the same probed IFU signals. It produces sticky per-thread hang flags, the wait-mask cause captured at detection, and per-thread maximum-wait statistics for end-of-test reporting.

## Interface
- TIMEOUT, 20000: consecutive WAIT cycles that constitute a hang; legal range 2 to 2^CNT_W-1.
- CNT_W, 16: width of the wait counters and statistics registers.
- clk  in  1  core clock; all state changes on posedge.
- rst_l  in  1  reset; asynchronous, active-low.
- mon_en  in  1  monitor enable; when 0, counters hold and no new hang is flagged.
- thr_state0..thr_state3  in  5 each  thread FSM state, decoded with `THRFSM_WAIT from ifu.tmp.h.
- wm_imiss, wm_other, wm_stbwait  in  4 each  per-thread wait masks, bit n = thread n.
- hang_clr  in  4  per-thread clear of the sticky hang flag and cause.
- rd_tid  in  2  thread select for the statistics read port.
- hang_vld  out  4  sticky hang flag per thread.
- hang_pulse  out  4  one-cycle pulse on the cycle hang_vld bit sets.
- hang_any  out  1  OR of hang_vld, registered.
- hang_cause  out  12  {imiss,other,stbwait} per thread; thread n occupies bits [3n+2:3n].
- max_wait  out  CNT_W  largest completed-or-current wait run of thread rd_tid; combinational read of registers.
- wait_cnt_rd  out  CNT_W  live wait counter of thread rd_tid.

## Operation
- Per-thread FSM with states IDLE, WAITING, and HUNG. All threads reset to IDLE.
  - IDLE -> WAITING: thr_stateN == `THRFSM_WAIT and mon_en. In the same edge, cnt <= 1.
  - WAITING -> WAITING: still WAIT. cnt <= cnt+1; it saturates at 2^CNT_W-1.
  - WAITING -> HUNG: on the edge where cnt+1 == TIMEOUT, with mon_en high.
    - hang_vld[n] <= 1 and hang_pulse[n] <= 1.
    - hang_cause[n] <= {wm_imiss[n], wm_other[n], wm_stbwait[n]}, sampled that cycle.
  - WAITING/HUNG -> IDLE: thr_stateN != `THRFSM_WAIT.
    - max[n] <= max(max[n], cnt).
    - cnt <= 0.
    - hang_vld is not cleared.
  - HUNG: cnt keeps counting (saturating). No further pulse is issued.
- Any X/Z on thr_stateN is treated as not-WAIT, i.e. the thread goes to IDLE. This avoids false hangs during the early-fetch X window.
- hang_clr[n] clears hang_vld[n] and hang_cause[n] next edge. If a hang detect for thread n occurs on the same edge, the set wins and the new cause is loaded.
- mon_en=0 behaviour:
  - FSM state and cnt freeze.
  - max is not updated.
  - hang_pulse is 0.
  - hang_clr still acts.
- max_wait returns max(max[rd_tid], cnt[rd_tid]), so a run in progress is visible.
- Threads are fully independent; simultaneous hangs on several threads set their bits on the same edge.

## Timing
- Reset (async, rst_l low) values:
  - hang_vld=0, hang_pulse=0, hang_any=0, hang_cause=0.
  - All cnt and max registers = 0.
  - max_wait=0 and wait_cnt_rd=0.
- Detection latency: when the thread is first sampled WAIT at edge k, hang_vld rises after edge k+TIMEOUT-1, i.e. TIMEOUT sampled WAIT cycles.
- hang_any lags hang_vld by one cycle.
- Reset asserted mid-run clears everything immediately. Counting restarts from 1 at the first WAIT edge after rst_l deasserts.
- A run of exactly TIMEOUT-1 WAIT cycles followed by a non-WAIT cycle must not flag.

## Test plan
- Hold thread 0 in WAIT with wm_imiss[0]=1, TIMEOUT=8 -> hang_pulse[0] single pulse after the 8th WAIT edge; hang_vld=4'b0001; hang_cause[2:0]=3'b100; hang_any one cycle later.
- Thread 1 WAIT for 7 cycles, RUN for 1, WAIT for 7, with TIMEOUT=8 -> no hang; max_wait with rd_tid=1 reads 7.
- Hang on thread 2, then pulse hang_clr[2] while it is still WAIT -> hang_vld[2] clears with no re-pulse. Assert hang_clr[2] on the detect edge of a fresh run -> the flag stays set.
- Drop mon_en for 5 cycles mid-run on thread 3 (count 4, TIMEOUT=8) -> wait_cnt_rd holds 4; the hang fires 4 enabled WAIT cycles after re-enable.
- Assert rst_l low at count 6 on all threads -> all outputs 0 asynchronously. Drive thr_state0=5'bx for 20 cycles -> no hang.

Source files
------------

// File: rtl/thrfsm_hang_det.sv
// Per-thread hang detector: flags any IFU thread held in the WAIT state for TIMEOUT
// consecutive sampled cycles, keeps the wait cause and per-thread maximum-wait statistics.
`ifndef THRFSM_WAIT
`define THRFSM_WAIT 5'b00001
`endif

module thrfsm_hang_det #(
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             mon_en,
  input  logic [4:0]       thr_state0,
  input  logic [4:0]       thr_state1,
  input  logic [4:0]       thr_state2,
  input  logic [4:0]       thr_state3,
  input  logic [3:0]       wm_imiss,
  input  logic [3:0]       wm_other,
  input  logic [3:0]       wm_stbwait,
  input  logic [3:0]       hang_clr,
  input  logic [1:0]       rd_tid,
  output logic [3:0]       hang_vld,
  output logic [3:0]       hang_pulse,
  output logic             hang_any,
  output logic [11:0]      hang_cause,
  output logic [CNT_W-1:0] max_wait,
  output logic [CNT_W-1:0] wait_cnt_rd
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_HUNG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W:0]   TIMEOUT_X = (CNT_W+1)'(TIMEOUT);

  state_t           r_state [4];
  logic [CNT_W-1:0] r_cnt   [4];
  logic [CNT_W-1:0] r_max   [4];

  logic [4:0]       w_thr_state [4];
  logic [3:0]       w_is_wait;
  logic [3:0]       w_detect;
  logic [CNT_W-1:0] w_cnt_sel;
  logic [CNT_W-1:0] w_max_sel;

  assign w_thr_state[0] = thr_state0;
  assign w_thr_state[1] = thr_state1;
  assign w_thr_state[2] = thr_state2;
  assign w_thr_state[3] = thr_state3;

  // Case equality keeps an X/Z state from ever matching WAIT during the early-fetch window.
  always_comb begin
    w_is_wait = '0;
    w_detect  = '0;
    for (int n = 0; n < 4; n++) begin
      w_is_wait[n] = (w_thr_state[n] === `THRFSM_WAIT);
      w_detect[n]  = mon_en && w_is_wait[n] && (r_state[n] == ST_WAITING) &&
                     (({1'b0, r_cnt[n]} + (CNT_W+1)'(1)) == TIMEOUT_X);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hang_vld   <= '0;
      hang_pulse <= '0;
      hang_any   <= 1'b0;
      hang_cause <= '0;
      for (int n = 0; n < 4; n++) begin
        r_state[n] <= ST_IDLE;
        r_cnt[n]   <= '0;
        r_max[n]   <= '0;
      end
    end else begin
      hang_any <= |hang_vld;
      for (int n = 0; n < 4; n++) begin
        hang_pulse[n] <= w_detect[n];
        // A detect on the same edge as a clear wins and reloads the cause.
        if (w_detect[n]) begin
          hang_vld[n]         <= 1'b1;
          hang_cause[3*n +: 3] <= {wm_imiss[n], wm_other[n], wm_stbwait[n]};
        end else if (hang_clr[n]) begin
          hang_vld[n]         <= 1'b0;
          hang_cause[3*n +: 3] <= 3'b000;
        end
        if (mon_en) begin
          case (r_state[n])
            ST_IDLE: begin
              if (w_is_wait[n]) begin
                r_state[n] <= ST_WAITING;
                r_cnt[n]   <= CNT_W'(1);
              end
            end
            ST_WAITING, ST_HUNG: begin
              if (!w_is_wait[n]) begin
                r_state[n] <= ST_IDLE;
                r_cnt[n]   <= '0;
                if (r_cnt[n] > r_max[n]) r_max[n] <= r_cnt[n];
              end else begin
                if (w_detect[n]) r_state[n] <= ST_HUNG;
                if (r_cnt[n] != CNT_SAT) r_cnt[n] <= r_cnt[n] + CNT_W'(1);
              end
            end
            default: begin
              r_state[n] <= ST_IDLE;
              r_cnt[n]   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign w_cnt_sel   = r_cnt[rd_tid];
  assign w_max_sel   = r_max[rd_tid];
  assign wait_cnt_rd = w_cnt_sel;
  assign max_wait    = (w_cnt_sel > w_max_sel) ? w_cnt_sel : w_max_sel;

endmodule

// File: tb/tb_thrfsm_hang_det.sv
// Directed bench for thrfsm_hang_det with TIMEOUT=8; expected values are hand-derived.
`ifndef THRFSM_WAIT
`define THRFSM_WAIT 5'b00001
`endif

module tb_thrfsm_hang_det;
  localparam int CNT_W = 16;
  localparam logic [4:0] ST_W = `THRFSM_WAIT;
  localparam logic [4:0] ST_R = 5'b00101;

  logic clk = 1'b0;
  logic rst_l, mon_en;
  logic [4:0] thr_state0, thr_state1, thr_state2, thr_state3;
  logic [3:0] wm_imiss, wm_other, wm_stbwait, hang_clr;
  logic [1:0] rd_tid;
  logic [3:0] hang_vld, hang_pulse;
  logic hang_any;
  logic [11:0] hang_cause;
  logic [CNT_W-1:0] max_wait, wait_cnt_rd;

  int checks = 0;
  int failures = 0;

  thrfsm_hang_det #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_l(rst_l), .mon_en(mon_en),
    .thr_state0(thr_state0), .thr_state1(thr_state1),
    .thr_state2(thr_state2), .thr_state3(thr_state3),
    .wm_imiss(wm_imiss), .wm_other(wm_other), .wm_stbwait(wm_stbwait),
    .hang_clr(hang_clr), .rd_tid(rd_tid),
    .hang_vld(hang_vld), .hang_pulse(hang_pulse), .hang_any(hang_any),
    .hang_cause(hang_cause), .max_wait(max_wait), .wait_cnt_rd(wait_cnt_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0; mon_en = 1'b1;
    thr_state0 = ST_R; thr_state1 = ST_R; thr_state2 = ST_R; thr_state3 = ST_R;
    wm_imiss = '0; wm_other = '0; wm_stbwait = '0; hang_clr = '0; rd_tid = 2'd0;
    #12;
    chk("rst_vld", hang_vld, 0);
    chk("rst_pulse", hang_pulse, 0);
    chk("rst_any", hang_any, 0);
    chk("rst_cause", hang_cause, 0);
    chk("rst_max", max_wait, 0);
    chk("rst_cnt", wait_cnt_rd, 0);
    tick();
    rst_l = 1'b1;

    // Thread 0: hang after 8 WAIT edges, imiss cause.
    thr_state0 = ST_W; wm_imiss = 4'b0001;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("t0_cnt", wait_cnt_rd, i);
      chk("t0_novld", hang_vld, 0);
    end
    tick();
    chk("t0_vld", hang_vld, 4'b0001);
    chk("t0_pulse", hang_pulse, 4'b0001);
    chk("t0_cause", hang_cause, 12'h004);
    chk("t0_any_lag", hang_any, 0);
    tick();
    chk("t0_pulse_once", hang_pulse, 0);
    chk("t0_any", hang_any, 1);
    chk("t0_hung_cnt", wait_cnt_rd, 9);
    thr_state0 = ST_R;
    tick();
    chk("t0_cnt_idle", wait_cnt_rd, 0);
    chk("t0_max", max_wait, 9);
    chk("t0_sticky", hang_vld, 4'b0001);
    hang_clr = 4'b0001;
    tick();
    hang_clr = 4'b0000; wm_imiss = 4'b0000;
    chk("t0_clr_vld", hang_vld, 0);
    chk("t0_clr_cause", hang_cause, 0);
    tick();
    chk("t0_any_clr", hang_any, 0);

    // Thread 1: two 7-cycle runs never flag; max reads 7.
    rd_tid = 2'd1;
    thr_state1 = ST_W; ticks(7);
    chk("t1_cnt7", wait_cnt_rd, 7);
    thr_state1 = ST_R; tick();
    chk("t1_gap_cnt", wait_cnt_rd, 0);
    chk("t1_gap_max", max_wait, 7);
    thr_state1 = ST_W; ticks(7);
    chk("t1_novld", hang_vld, 0);
    chk("t1_max_live", max_wait, 7);
    thr_state1 = ST_R; tick();
    chk("t1_novld_end", hang_vld, 0);
    chk("t1_nopulse", hang_pulse, 0);
    chk("t1_max", max_wait, 7);

    // Thread 2: clear while still hung, then clear colliding with a fresh detect.
    rd_tid = 2'd2;
    thr_state2 = ST_W; ticks(8);
    chk("t2_vld", hang_vld, 4'b0100);
    chk("t2_pulse", hang_pulse, 4'b0100);
    tick();
    hang_clr = 4'b0100; tick(); hang_clr = 4'b0000;
    chk("t2_clr", hang_vld, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_norepulse", hang_pulse, 0);
      chk("t2_stay_clr", hang_vld, 0);
    end
    thr_state2 = ST_R; tick();
    thr_state2 = ST_W; wm_other = 4'b0100; ticks(7);
    chk("t2_pre_vld", hang_vld, 0);
    hang_clr = 4'b0100; tick(); hang_clr = 4'b0000;
    chk("t2_set_wins", hang_vld, 4'b0100);
    chk("t2_set_pulse", hang_pulse, 4'b0100);
    chk("t2_cause", hang_cause, 12'h080);
    thr_state2 = ST_R; wm_other = 4'b0000; hang_clr = 4'b0100; tick(); hang_clr = 4'b0000;
    chk("t2_final_clr", hang_vld, 0);

    // Thread 3: mon_en gap freezes the count mid-run.
    rd_tid = 2'd3;
    thr_state3 = ST_W; wm_stbwait = 4'b1000; ticks(4);
    chk("t3_cnt4", wait_cnt_rd, 4);
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold", wait_cnt_rd, 4);
    end
    chk("t3_novld_off", hang_vld, 0);
    mon_en = 1'b1; ticks(3);
    chk("t3_cnt7", wait_cnt_rd, 7);
    chk("t3_novld7", hang_vld, 0);
    tick();
    chk("t3_vld", hang_vld, 4'b1000);
    chk("t3_pulse", hang_pulse, 4'b1000);
    chk("t3_cause", hang_cause, 12'h200);
    thr_state3 = ST_R; wm_stbwait = 4'b0000; hang_clr = 4'b1000; tick(); hang_clr = 4'b0000;
    chk("t3_clr", hang_vld, 0);

    // All threads to count 6, then asynchronous reset mid-cycle.
    rd_tid = 2'd0;
    thr_state0 = ST_W; thr_state1 = ST_W; thr_state2 = ST_W; thr_state3 = ST_W;
    ticks(6);
    chk("all_cnt6", wait_cnt_rd, 6);
    #3 rst_l = 1'b0;
    #1;
    chk("arst_cnt", wait_cnt_rd, 0);
    chk("arst_max", max_wait, 0);
    chk("arst_vld", hang_vld, 0);
    chk("arst_any", hang_any, 0);
    chk("arst_cause", hang_cause, 0);
    tick();
    rst_l = 1'b1;
    thr_state0 = 5'bxxxxx; thr_state1 = ST_R; thr_state2 = ST_R; thr_state3 = ST_R;
    ticks(20);
    chk("x_novld", hang_vld, 0);
    chk("x_cnt", wait_cnt_rd, 0);
    thr_state0 = ST_W; tick();
    chk("restart_cnt1", wait_cnt_rd, 1);

    // Simultaneous hangs on threads 1 and 2.
    thr_state0 = ST_R; thr_state1 = ST_W; thr_state2 = ST_W;
    ticks(7);
    chk("sim_pre", hang_vld, 0);
    tick();
    chk("sim_vld", hang_vld, 4'b0110);
    chk("sim_pulse", hang_pulse, 4'b0110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
